// File: rtl/flag_branch_unit.sv
// Architectural N/Z/V flag register plus a branch resolver that evaluates decode's
// condition codes against it, stalling while a flag-writing instruction sits in EX.
module flag_branch_unit #(
    parameter int WIDTH = 16,
    parameter int OFS_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_hold,
    input  logic [3:0]       ex_alu_code,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_overflow,
    input  logic             ex_zero,
    input  logic             br_req,
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] br_pc_plus2,
    input  logic [OFS_W-1:0] br_offset,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             br_ack,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_target,
    output logic             br_stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HAZ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_v_q, flag_v_d;
    logic [2:0]       cond_q, cond_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [OFS_W-1:0] ofs_q, ofs_d;
    logic             br_ack_q, br_ack_d;
    logic             br_taken_q, br_taken_d;
    logic [WIDTH-1:0] br_target_q, br_target_d;
    logic             br_stall_q, br_stall_d;

    logic             wr_nzv_s;
    logic             wr_z_s;
    logic             flag_we_s;
    logic             hazard_s;
    logic             unused_s;

    // Only the sign bit of the ALU result feeds the flags.
    assign unused_s = ^ex_result[WIDTH-2:0];

    function automatic logic cond_true(input logic [2:0] c, input logic n, input logic z,
                                       input logic v);
        logic t;
        case (c)
            3'b000:  t = ~z;
            3'b001:  t = z;
            3'b010:  t = ~z & ~n;
            3'b011:  t = n;
            3'b100:  t = z | (~z & ~n);
            3'b101:  t = n | z;
            3'b110:  t = v;
            3'b111:  t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [WIDTH-1:0] calc_target(input logic [WIDTH-1:0] pc,
                                                     input logic [OFS_W-1:0] ofs);
        logic [WIDTH-1:0] ext;
        ext = {{(WIDTH-OFS_W){ofs[OFS_W-1]}}, ofs};
        return pc + (ext << 1);
    endfunction

    // Decode which flags the EX opcode writes.
    always_comb begin
        wr_nzv_s = 1'b0;
        wr_z_s   = 1'b0;
        case (ex_alu_code)
            4'b0000, 4'b0001:                   wr_nzv_s = 1'b1;
            4'b0010, 4'b0100, 4'b0101, 4'b0110: wr_z_s   = 1'b1;
            default: begin
                wr_nzv_s = 1'b0;
                wr_z_s   = 1'b0;
            end
        endcase
    end

    // A held flag-writer still blocks branch evaluation; it just doesn't write yet.
    assign hazard_s  = ex_valid & (wr_nzv_s | wr_z_s);
    assign flag_we_s = ex_valid & ~ex_hold;

    // Next flag register value.
    always_comb begin
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        flag_v_d = flag_v_q;
        if (flag_we_s && wr_nzv_s) begin
            flag_n_d = ex_result[WIDTH-1];
            flag_z_d = ex_zero;
            flag_v_d = ex_overflow;
        end else if (flag_we_s && wr_z_s) begin
            flag_z_d = ex_zero;
        end else begin
            flag_z_d = flag_z_q;
        end
    end

    // Branch resolver next-state and registered outputs.
    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        pc_d        = pc_q;
        ofs_d       = ofs_q;
        br_ack_d    = 1'b0;
        br_stall_d  = 1'b0;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        case (state_q)
            ST_IDLE: begin
                if (br_req) begin
                    cond_d = br_cond;
                    pc_d   = br_pc_plus2;
                    ofs_d  = br_offset;
                    if (hazard_s) begin
                        state_d    = ST_HAZ;
                        br_stall_d = 1'b1;
                    end else begin
                        state_d     = ST_ACK;
                        br_ack_d    = 1'b1;
                        br_taken_d  = cond_true(br_cond, flag_n_q, flag_z_q, flag_v_q);
                        br_target_d = calc_target(br_pc_plus2, br_offset);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HAZ: begin
                if (hazard_s) begin
                    state_d    = ST_HAZ;
                    br_stall_d = 1'b1;
                end else begin
                    state_d     = ST_ACK;
                    br_ack_d    = 1'b1;
                    br_taken_d  = cond_true(cond_q, flag_n_q, flag_z_q, flag_v_q);
                    br_target_d = calc_target(pc_q, ofs_q);
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            cond_q      <= 3'b000;
            pc_q        <= {WIDTH{1'b0}};
            ofs_q       <= {OFS_W{1'b0}};
            br_ack_q    <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= {WIDTH{1'b0}};
            br_stall_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flag_n_q    <= flag_n_d;
            flag_z_q    <= flag_z_d;
            flag_v_q    <= flag_v_d;
            cond_q      <= cond_d;
            pc_q        <= pc_d;
            ofs_q       <= ofs_d;
            br_ack_q    <= br_ack_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            br_stall_q  <= br_stall_d;
        end
    end

    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;
    assign flag_v    = flag_v_q;
    assign br_ack    = br_ack_q;
    assign br_taken  = br_taken_q;
    assign br_target = br_target_q;
    assign br_stall  = br_stall_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: flag update rules, hazard stalls, targets, reset, cond sweep.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid, ex_hold, ex_overflow, ex_zero;
    logic [3:0]  ex_alu_code;
    logic [15:0] ex_result;
    logic        br_req;
    logic [2:0]  br_cond;
    logic [15:0] br_pc_plus2;
    logic [8:0]  br_offset;
    logic        flag_n, flag_z, flag_v, br_ack, br_taken, br_stall;
    logic [15:0] br_target;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    flag_branch_unit #(.WIDTH(16), .OFS_W(9)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_hold(ex_hold), .ex_alu_code(ex_alu_code),
        .ex_result(ex_result), .ex_overflow(ex_overflow), .ex_zero(ex_zero),
        .br_req(br_req), .br_cond(br_cond), .br_pc_plus2(br_pc_plus2), .br_offset(br_offset),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
        .br_ack(br_ack), .br_taken(br_taken), .br_target(br_target), .br_stall(br_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_hold = 1'b0; ex_alu_code = 4'h0;
        ex_result = 16'h0000; ex_overflow = 1'b0; ex_zero = 1'b0;
    endtask

    task automatic set_ex(input logic [3:0] code, input logic [15:0] res, input logic ovf,
                          input logic zr, input logic hold);
        ex_valid = 1'b1; ex_hold = hold; ex_alu_code = code;
        ex_result = res; ex_overflow = ovf; ex_zero = zr;
    endtask

    // Request a branch, wait (bounded) for ack, return cycles-to-ack, leave FSM in IDLE.
    task automatic branch(input logic [2:0] c, input logic [15:0] pc, input logic [8:0] off,
                          output int cycles);
        br_req = 1'b1; br_cond = c; br_pc_plus2 = pc; br_offset = off;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!br_ack && cycles < 20);
        check("ack_seen", {31'd0, br_ack}, 32'd1);
        br_req = 1'b0;
        tick();
    endtask

    function automatic logic exp_taken(input logic [2:0] c, input logic n, input logic z,
                                       input logic v);
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        clear_ex();
        br_req = 1'b0; br_cond = 3'd0; br_pc_plus2 = 16'h0; br_offset = 9'h0;

        // 1: reset state and a simple no-hazard branch
        tick(); tick();
        check("rst_flags", {29'd0, flag_n, flag_z, flag_v}, 32'd0);
        check("rst_ack", {31'd0, br_ack}, 32'd0);
        check("rst_stall", {31'd0, br_stall}, 32'd0);
        check("rst_taken", {31'd0, br_taken}, 32'd0);
        check("rst_target", {16'd0, br_target}, 32'h0);
        rst = 1'b0;
        branch(3'b001, 16'h0010, 9'h004, lat);
        check("t1_lat", lat, 32'd1);
        check("t1_taken", {31'd0, br_taken}, 32'd0);
        check("t1_target", {16'd0, br_target}, 32'h0018);

        // 2: ADD with overflow in EX alongside a cond=110 request
        set_ex(4'b0000, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        br_req = 1'b1; br_cond = 3'b110; br_pc_plus2 = 16'h0020; br_offset = 9'h010;
        tick();
        check("t2_stall", {31'd0, br_stall}, 32'd1);
        check("t2_noack", {31'd0, br_ack}, 32'd0);
        check("t2_flags", {29'd0, flag_n, flag_z, flag_v}, 32'b001);
        clear_ex();
        tick();
        check("t2_ack", {31'd0, br_ack}, 32'd1);
        check("t2_stall_off", {31'd0, br_stall}, 32'd0);
        check("t2_taken", {31'd0, br_taken}, 32'd1);
        check("t2_target", {16'd0, br_target}, 32'h0040);
        br_req = 1'b0;
        tick();
        check("t2_ack_pulse", {31'd0, br_ack}, 32'd0);

        // 3: XOR producing zero, held for two cycles
        set_ex(4'b0010, 16'h0000, 1'b0, 1'b1, 1'b1);
        tick();
        check("t3_held_z", {31'd0, flag_z}, 32'd0);
        br_req = 1'b1; br_cond = 3'b001; br_pc_plus2 = 16'h0100; br_offset = 9'h000;
        tick();
        check("t3_stall1", {31'd0, br_stall}, 32'd1);
        check("t3_z_still0", {31'd0, flag_z}, 32'd0);
        ex_hold = 1'b0;
        tick();
        check("t3_stall2", {31'd0, br_stall}, 32'd1);
        check("t3_flags", {29'd0, flag_n, flag_z, flag_v}, 32'b011);
        clear_ex();
        tick();
        check("t3_ack", {31'd0, br_ack}, 32'd1);
        check("t3_taken", {31'd0, br_taken}, 32'd1);
        br_req = 1'b0;
        tick();

        // 4: non-flag-writing ops leave N/Z/V alone and cause no stall
        set_ex(4'b1000, 16'h8000, 1'b0, 1'b0, 1'b0);
        branch(3'b001, 16'h0200, 9'h000, lat);
        check("t4_lat", lat, 32'd1);
        check("t4_taken", {31'd0, br_taken}, 32'd1);
        set_ex(4'b0011, 16'h8000, 1'b0, 1'b0, 1'b0);
        tick();
        set_ex(4'b0111, 16'h8000, 1'b0, 1'b0, 1'b0);
        tick();
        set_ex(4'b0000, 16'h8000, 1'b0, 1'b0, 1'b1);
        tick();
        check("t4_flags", {29'd0, flag_n, flag_z, flag_v}, 32'b011);
        clear_ex();

        // 5: target wrap-around and hold after ack
        branch(3'b111, 16'h0000, 9'h1FF, lat);
        check("t5_target_neg", {16'd0, br_target}, 32'hFFFE);
        branch(3'b111, 16'hFF00, 9'h0FF, lat);
        check("t5_target_wrap", {16'd0, br_target}, 32'h00FE);
        tick();
        check("t5_target_hold", {16'd0, br_target}, 32'h00FE);

        // 6: reset while stalled drops the request
        set_ex(4'b0001, 16'h8000, 1'b1, 1'b0, 1'b0);
        br_req = 1'b1; br_cond = 3'b111; br_pc_plus2 = 16'h0300; br_offset = 9'h001;
        tick();
        check("t6_stall", {31'd0, br_stall}, 32'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_ack", {31'd0, br_ack}, 32'd0);
        check("t6_rst_stall", {31'd0, br_stall}, 32'd0);
        check("t6_rst_flags", {29'd0, flag_n, flag_z, flag_v}, 32'd0);
        rst = 1'b0; br_req = 1'b0; clear_ex();
        tick();
        check("t6_no_ack", {31'd0, br_ack}, 32'd0);

        // Sweep every condition over every N/Z/V combination
        for (int f = 0; f < 8; f++) begin
            logic [2:0] fl;
            fl = f[2:0];
            set_ex(4'b0000, {fl[2], 15'h0}, fl[0], fl[1], 1'b0);
            tick();
            clear_ex();
            check("sw_flags", {29'd0, flag_n, flag_z, flag_v}, {29'd0, fl});
            for (int c = 0; c < 8; c++) begin
                logic [2:0] cc;
                cc = c[2:0];
                branch(cc, 16'h0400, 9'h002, lat);
                check($sformatf("sw_nzv%0d_c%0d", f, c), {31'd0, br_taken},
                      {31'd0, exp_taken(cc, fl[2], fl[1], fl[0])});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
